// File: rtl/merge_pkt_num_alloc_if.sv
// Beat-in / tagged-beat-out bundle for the merge packet-number allocator.
interface merge_pkt_num_alloc_if #(
  parameter int SEG_NUM = 8
);
  logic [SEG_NUM-1:0]    in_sop;
  logic [SEG_NUM-1:0]    in_eop;
  logic [SEG_NUM-1:0]    in_dval;
  logic [12*SEG_NUM-1:0] in_zero_num;
  logic [32*SEG_NUM-1:0] in_dout;
  logic                  in_ready;
  logic [SEG_NUM-1:0]    out_sop;
  logic [SEG_NUM-1:0]    out_eop;
  logic [SEG_NUM-1:0]    out_dval;
  logic [4*SEG_NUM-1:0]  out_packet_num;
  logic [12*SEG_NUM-1:0] out_zero_num;
  logic [32*SEG_NUM-1:0] out_dout;
  logic                  out_err;

  modport slave (
    input  in_sop, in_eop, in_dval, in_zero_num, in_dout,
    output in_ready,
    output out_sop, out_eop, out_dval, out_packet_num, out_zero_num, out_dout, out_err
  );

  modport master (
    output in_sop, in_eop, in_dval, in_zero_num, in_dout,
    input  in_ready,
    input  out_sop, out_eop, out_dval, out_packet_num, out_zero_num, out_dout, out_err
  );
endinterface

// File: rtl/merge_pkt_num_alloc.sv
// Tags each segment of a beat with a packet number 1..PKT_MAX, splitting beats
// that carry more packets than crossbar elements over several output cycles.
module merge_pkt_num_alloc #(
  parameter int SEG_NUM = 8,
  parameter int PKT_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  merge_pkt_num_alloc_if.slave    bus
);

  localparam int PASS_NUM = (SEG_NUM + PKT_MAX - 1) / PKT_MAX;
  localparam int PASS_W   = $clog2(PASS_NUM) + 1;

  logic [PASS_W-1:0]     pass_cnt;
  logic                  open_pkt;
  logic [4:0]            id [SEG_NUM];
  logic [4:0]            total;
  logic [4:0]            base;
  logic [4:0]            limit;
  logic                  ready_c;

  logic [SEG_NUM-1:0]    sop_p0, eop_p0, dval_p0;
  logic [4*SEG_NUM-1:0]  pnum_p0;
  logic [12*SEG_NUM-1:0] zn_p0;
  logic [32*SEG_NUM-1:0] dout_p0;
  logic                  err_p0;
  logic                  open_p0;

  logic [SEG_NUM-1:0]    sop_p1, eop_p1, dval_p1;
  logic [4*SEG_NUM-1:0]  pnum_p1;
  logic [12*SEG_NUM-1:0] zn_p1;
  logic [32*SEG_NUM-1:0] dout_p1;
  logic                  err_p1;

  // Stage p0: raw ids, pass window and framing check on the sampled beat
  always_comb begin
    id[0] = 5'd1;
    for (int j = 1; j < SEG_NUM; j++)
      id[j] = id[j-1] + {4'd0, bus.in_sop[j] & bus.in_dval[j]};
    total = '0;
    for (int j = 0; j < SEG_NUM; j++)
      if (bus.in_dval[j]) total = id[j];
  end

  assign base         = 5'(int'(pass_cnt) * PKT_MAX);
  assign limit        = base + 5'(PKT_MAX);
  assign ready_c      = (total <= limit);
  assign bus.in_ready = !rst && ready_c;

  always_comb begin
    sop_p0  = '0;
    eop_p0  = '0;
    dval_p0 = '0;
    pnum_p0 = '0;
    zn_p0   = '0;
    dout_p0 = '0;
    err_p0  = 1'b0;
    open_p0 = open_pkt;
    for (int j = 0; j < SEG_NUM; j++) begin
      if (bus.in_dval[j] && (id[j] > base) && (id[j] <= limit)) begin
        sop_p0[j]           = bus.in_sop[j];
        eop_p0[j]           = bus.in_eop[j];
        dval_p0[j]          = 1'b1;
        pnum_p0[4*j +: 4]   = 4'(id[j] - base);
        zn_p0[12*j +: 12]   = bus.in_zero_num[12*j +: 12];
        dout_p0[32*j +: 32] = bus.in_dout[32*j +: 32];
        // Open state walks segments in order so mid-beat packets are judged correctly
        if (bus.in_sop[j]) begin
          err_p0  = err_p0 | open_p0;
          open_p0 = 1'b1;
        end else begin
          err_p0  = err_p0 | !open_p0;
        end
        if (bus.in_eop[j]) open_p0 = 1'b0;
      end
    end
  end

  // Stage p1: registered outputs and pass/open state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      open_pkt <= 1'b0;
      sop_p1   <= '0;
      eop_p1   <= '0;
      dval_p1  <= '0;
      pnum_p1  <= '0;
      zn_p1    <= '0;
      dout_p1  <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (ready_c || pass_cnt == PASS_W'(PASS_NUM - 1))
        pass_cnt <= '0;
      else
        pass_cnt <= pass_cnt + 1'b1;
      open_pkt <= open_p0;
      sop_p1   <= sop_p0;
      eop_p1   <= eop_p0;
      dval_p1  <= dval_p0;
      pnum_p1  <= pnum_p0;
      zn_p1    <= zn_p0;
      dout_p1  <= dout_p0;
      err_p1   <= err_p0;
    end
  end

  assign bus.out_sop        = sop_p1;
  assign bus.out_eop        = eop_p1;
  assign bus.out_dval       = dval_p1;
  assign bus.out_packet_num = pnum_p1;
  assign bus.out_zero_num   = zn_p1;
  assign bus.out_dout       = dout_p1;
  assign bus.out_err        = err_p1;

endmodule
